if_fetch_unit: RTL

- Instruction-fetch stage controller and the producer side of the IF/ID pipeline register.
- Holds the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Delivers fetched instructions with PC+4 into IF/ID, or inserts NOP bubbles while waiting.
- Honours hazard stalls, and on branch/jump redirects discards in-flight fetches and flushes IF/ID.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 63 ++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: hazard, redirect, instruction-memory and IF/ID signals of the fetch stage
interface if_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] newPC;
  logic        ifid_en;
  logic        ifid_flush;
  modport master (
    input  stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instruction, newPC, ifid_en, ifid_flush
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instruction, newPC, ifid_en, ifid_flush
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC holder and single-outstanding fetch controller feeding the IF/ID register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, hold_buf_q, hold_buf_d, pc_next;
  logic        deliver;
  assign pc_next = pc_q + PC_STEP;
  // IF/ID and memory-side outputs; a word is delivered only when neither stalled nor flushed
  always_comb begin
    deliver         = !bus.stall && !bus.redirect && ((state_q == WAIT && bus.imem_rvalid) || state_q == HOLD);
    bus.imem_req    = !rst && state_q == FETCH;
    bus.imem_addr   = pc_q;
    bus.ifid_en     = !rst && !bus.stall;
    bus.ifid_flush  = !rst && bus.redirect;
    bus.instruction = (rst || !deliver) ? NOP_INSTR : (state_q == HOLD ? hold_buf_q : bus.imem_rdata);
    bus.newPC       = rst ? RESET_PC : (deliver ? pc_next : pc_q);
  end
  // next state; a redirect overrides everything and leaves DISCARD behind if a response is still owed
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_buf_d = hold_buf_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      state_d = ((state_q == FETCH && bus.imem_ready) ||
                 ((state_q == WAIT || state_q == DISCARD) && !bus.imem_rvalid)) ? DISCARD : FETCH;
    end else begin
      case (state_q)
        FETCH: state_d = bus.imem_ready ? WAIT : FETCH;
        WAIT: if (bus.imem_rvalid) begin
          state_d    = bus.stall ? HOLD : FETCH;
          pc_d       = bus.stall ? pc_q : pc_next;
          hold_buf_d = bus.stall ? bus.imem_rdata : hold_buf_q;
        end
        HOLD: if (!bus.stall) begin
          state_d = FETCH;
          pc_d    = pc_next;
        end
        default: state_d = bus.imem_rvalid ? FETCH : DISCARD;
      endcase
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      hold_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_buf_q <= hold_buf_d;
    end
  end
endmodule
